uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receiver companion to uart_tx: recovers 8N1 bytes (LSB first) from the serial line.
//  Samples at mid-bit using a CLOCK_FREQ/BAUD_RATE cycle counter.
//  Presents each good byte with a 1-cycle valid strobe and flags framing errors.
//  Sits directly downstream of uart_tx; benches loop uart_tx.tx into uart_rx.rx.
// PARAMETERS
//  CLOCK_FREQ  1_843_200  system clock frequency, Hz
//  BAUD_RATE   115_200    line rate, bits/s
//  CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE is a derived localparam (16 at defaults).
//  It must be even and >= 4, otherwise elaboration fails via $error.
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-low reset
//  rx         in   1  serial line, idle high, asynchronous to clk
//  data_out   out  8  last correctly received byte
//  valid      out  1  1-cycle pulse: data_out updated this cycle
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  busy       out  1  high while a frame is being received
// BEHAVIOUR
//  Reset (rst=0, async) values:
//   - data_out=8'h00, valid=0, frame_err=0, busy=0.
//   - Synchronizer flops = 1, state=IDLE, counters=0.
//  Input path:
//   - rx passes through a 2-flop synchronizer, giving rx_s.
//   - All decisions use rx_s. There is no other filtering.
//  State machine:
//   IDLE:
//    - On rx_s falling edge (prev 1, now 1->0): clear cnt, busy<=1, go START.
//   START:
//    - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
//    - If 1 (glitch): go IDLE, busy<=0, no strobes.
//    - If 0: clear cnt, bit_idx=0, go DATA.
//   DATA:
//    - At cnt==CLKS_PER_BIT-1, sample rx_s into shift reg bit bit_idx and clear cnt.
//    - After bit_idx==7, go STOP.
//   STOP:
//    - At cnt==CLKS_PER_BIT-1, sample rx_s.
//    - If 1: data_out<=shift reg, valid<=1 for one cycle, busy<=0, go IDLE.
//    - If 0: frame_err<=1 for one cycle, data_out unchanged, go BREAK.
//   BREAK:
//    - Stay until rx_s==1, then busy<=0, go IDLE.
//    - Line held low (break) must not generate a new frame.
//  Counter: cnt is $clog2(CLKS_PER_BIT) bits wide and never wraps past CLKS_PER_BIT-1.
//  Latency: valid (or frame_err) rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles
//   after rx falls (154 at defaults); bench tolerance +/-1 cycle.
//  Back-to-back frames:
//   - IDLE is re-entered at mid-stop.
//   - A start edge arriving any time after that is accepted; no gap is required.
//  valid and frame_err are never high in the same cycle.
//  busy=1 from the cycle after the edge is detected until the cycle IDLE is re-entered.
//  Reset mid-frame: immediate return to reset values; the partial byte is discarded.
//   The next falling edge after release starts a fresh frame.
// TESTING
//  1. Loopback: uart_tx sends 8'h55 -> exactly one valid pulse, data_out=8'h55,
//     frame_err never 1, pulse 154+/-1 cycles after tx falls.
//  2. Back-to-back: uart_tx sends 8'h00, then 8'hFF with start asserted as soon as
//     busy drops -> two valid pulses, data 8'h00 then 8'hFF.
//  3. Glitch: drive rx low for 4 cycles, then high -> busy pulses, then returns to 0;
//     no valid, no frame_err.
//  4. Framing error: hand-drive 8'hA5 with stop bit low, hold rx low 40 cycles, release ->
//     one frame_err pulse, valid stays 0, data_out keeps its prior value,
//     busy falls only after rx returns high.
//  5. Reset mid-frame: drop rst during data bit 4 of 8'hC3 for 2 cycles -> all outputs
//     go to reset values at once, no valid for that frame; the next frame 8'h3C is
//     received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: a 2-flop synchronizer feeds a mid-bit sampling FSM that
// delivers each good byte with a one-cycle valid strobe and flags bad stop bits.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLOCK_FREQ = 1_843_200,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // An odd or tiny ratio leaves no well-defined mid-bit sample point.
    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_ratio
            $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end

                // A start bit that is high again at its midpoint was only a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out <= shreg;
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a hand-written 8N1 driver on rx and a negedge
// monitor that counts valid/frame_err/busy activity.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;
    localparam int LAT = 154;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc       = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cyc = 0;
    logic [7:0] data_log[$];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampling on the falling edge keeps the monitor clear of the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                valid_cnt <= valid_cnt + 1;
                valid_cyc <= cyc;
                data_log.push_back(data_out);
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (valid && frame_err) both_cnt <= both_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t_fall);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx  = 1'b1;
        tick(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", data_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        rst = 1'b1;
        tick(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_loopback;
        int v0, f0, t, lat;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, t);
        tick(4);
        lat = valid_cyc - t;
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL loop_valid_count got %0d expected 1", valid_cnt - v0); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL loop_data got %h expected 55", data_out); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL loop_ferr got %0d expected 0", ferr_cnt - f0); end
        checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL loop_latency got %0d expected %0d+/-1", lat, LAT); end
    endtask

    task automatic test_back_to_back;
        int v0, n0, t;
        logic timed_out;
        logic [7:0] d0, d1;
        v0 = valid_cnt;
        n0 = data_log.size();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b0);
        rx = 1'b1;
        timed_out = 1'b1;
        for (int k = 0; k < 3 * CPB; k++) begin
            tick(1);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop got timeout expected busy low"); end
        send_frame(8'hFF, 1'b1, t);
        tick(4);
        d0 = (data_log.size() > n0)     ? data_log[n0]     : 8'hxx;
        d1 = (data_log.size() > n0 + 1) ? data_log[n0 + 1] : 8'hxx;
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d expected 2", valid_cnt - v0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL b2b_first_data got %h expected 00", d0); end
        checks++; if (d1 !== 8'hFF) begin errors++; $display("FAIL b2b_second_data got %h expected ff", d1); end
    endtask

    task automatic test_glitch;
        int v0, f0, b0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        checks++; if (busy_cnt <= b0) begin errors++; $display("FAIL glitch_busy_pulse got %0d busy cycles expected >0", busy_cnt - b0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b expected 0", busy); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d expected 0", valid_cnt - v0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_error;
        int v0, f0, t;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, t);
        tick(40);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d expected 1", ferr_cnt - f0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d expected 0", valid_cnt - v0); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept got %h expected ff", data_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break got %b expected 1", busy); end
        rx = 1'b1;
        tick(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b expected 0", busy); end
        tick(30);
        checks++; if (ferr_cnt - f0 !== 1 || valid_cnt - v0 !== 0) begin
            errors++; $display("FAIL ferr_after_break got ferr=%0d valid=%0d expected 1 0", ferr_cnt - f0, valid_cnt - v0);
        end
    endtask

    task automatic test_reset_midframe;
        int v0, f0, t;
        logic [7:0] d;
        d  = 8'hC3;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        tick(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy); end
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h expected 00", data_out); end
        checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes got %b%b expected 00", valid, frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b expected 0", busy); end
        tick(2);
        rst = 1'b1;
        tick(20);
        send_frame(8'h3C, 1'b1, t);
        tick(4);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL mid_valid_count got %0d expected 1", valid_cnt - v0); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL mid_next_data got %h expected 3c", data_out); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL mid_ferr got %0d expected 0", ferr_cnt - f0); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_ferr_together got %0d expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
